adder_accumulator: RTL and testbench

- Multi-operand accumulator that sits around the team's combinational `fullAdder4` (parameter `width`; ports `a`, `b`, `Cin`, `sum`, `Cout`).
- It drives the adder's operand inputs and consumes its `sum`/`Cout` outputs. It accepts a stream of operands via valid/ready and sums a commanded number of terms.
- It presents the wrapped total plus a sticky carry-out flag through a valid/ready result port.
- The adder is instantiated externally and wired to the `add_*` ports.

---
 rtl/adder_accumulator.sv | 75 +++++++
 tb/tb_adder_accumulator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_accumulator.sv
// Sums num_terms operands through an external adder and returns the wrapped total plus sticky carry.
// Latency: one operand per cycle, result one cycle after the last accept; the result holds until res_ready.
module adder_accumulator #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  output logic             busy,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_overflow,
  input  logic             res_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  assign add_a        = acc;
  assign add_b        = op_data;
  assign add_cin      = 1'b0;
  assign op_ready     = (state == ACCUM);
  assign res_valid    = (state == HOLD);
  assign busy         = (state != IDLE);
  assign res_data     = acc;
  assign res_overflow = ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= num_terms;
            // A zero-term job goes straight to the result with a zero total.
            state <= (num_terms == '0) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (op_valid) begin
            acc <= add_sum;
            ovf <= ovf | add_cout;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_accumulator.sv
// Randomised and directed bench for adder_accumulator against a running-total reference model.
module tb_adder_accumulator;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_terms = '0;
  logic             busy;
  logic             op_valid = 1'b0;
  logic [WIDTH-1:0] op_data = '0;
  logic             op_ready;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_overflow;
  logic             res_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Stand-in for the external fullAdder4.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  adder_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms), .busy(busy),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_data(res_data), .res_overflow(res_overflow), .res_ready(res_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a job is "terms still owed" plus an unbounded running total.
  // Any carry out of a wrapped partial sum means the true total reached 2^WIDTH.
  int m_mode  = 0;   // 0 idle, 1 collecting operands, 2 result on offer
  int m_left  = 0;
  int m_total = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_left = 0; m_total = 0;
    end else begin
      case (m_mode)
        0: if (start) begin
             m_total = 0;
             m_left  = int'(num_terms);
             m_mode  = (num_terms == 0) ? 2 : 1;
           end
        1: if (op_valid) begin
             m_total += int'(op_data);
             m_left--;
             if (m_left == 0) m_mode = 2;
           end
        default: if (res_ready) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",         32'(busy),         32'(m_mode != 0));
      chk("op_ready",     32'(op_ready),     32'(m_mode == 1));
      chk("res_valid",    32'(res_valid),    32'(m_mode == 2));
      chk("res_data",     32'(res_data),     32'(m_total % (1 << WIDTH)));
      chk("res_overflow", 32'(res_overflow), 32'(m_total >= (1 << WIDTH)));
      chk("add_a",        32'(add_a),        32'(m_total % (1 << WIDTH)));
      chk("add_b",        32'(add_b),        32'(op_data));
      chk("add_cin",      32'(add_cin),      32'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n);
    start = 1'b1; num_terms = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int d);
    op_valid = 1'b1; op_data = WIDTH'(d);
    tick();
    op_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input int d, input int o);
    int waited = 0;
    while (!res_valid && waited < 40) begin
      tick();
      waited++;
    end
    chk({name, "_valid"}, 32'(res_valid), 32'd1);
    chk({name, "_data"},  32'(res_data),  32'(d));
    chk({name, "_ovf"},   32'(res_overflow), 32'(o));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);

    // 1 + 5 + 3 back to back
    start_job(3);
    feed(1); feed(5); feed(3);
    chk("j1_valid_next", 32'(res_valid), 32'd1);
    chk("j1_op_ready_hold", 32'(op_ready), 32'd0);
    expect_result("j1", 9, 0);

    // Wraparound, then ovf cleared by the next start
    start_job(2); feed(15); feed(15);
    expect_result("j2", 14, 1);
    start_job(2); feed(2); feed(5);
    expect_result("j3", 7, 0);

    // Zero-term job, operand offered but not taken
    op_valid = 1'b1; op_data = 4'd9;
    start_job(0);
    chk("j4_valid", 32'(res_valid), 32'd1);
    chk("j4_op_ready", 32'(op_ready), 32'd0);
    tick();
    op_valid = 1'b0;
    expect_result("j4", 0, 0);

    // Operand gaps and result backpressure
    start_job(3);
    feed(0); tick(); tick();
    feed(1); tick(); tick();
    feed(7);
    for (int i = 0; i < 3; i++) begin
      chk("j5_held_data", 32'(res_data), 32'd8);
      chk("j5_held_valid", 32'(res_valid), 32'd1);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("j5_idle_after", 32'(busy), 32'd0);

    // start during ACCUM and during the result handshake is ignored
    start_job(3);
    feed(1);
    start_job(1);
    feed(2); feed(3);
    chk("j6_data", 32'(res_data), 32'd6);
    res_ready = 1'b1; start = 1'b1; num_terms = 4'd2;
    tick();
    res_ready = 1'b0; start = 1'b0;
    chk("j6_start_ignored", 32'(busy), 32'd0);
    tick();
    chk("j6_still_idle", 32'(busy), 32'd0);

    // Reset mid-job discards it
    start_job(4); feed(1); feed(2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("j7_busy", 32'(busy), 32'd0);
    chk("j7_op_ready", 32'(op_ready), 32'd0);
    chk("j7_res_valid", 32'(res_valid), 32'd0);
    chk("j7_res_data", 32'(res_data), 32'd0);
    start_job(2); feed(4); feed(4);
    expect_result("j8", 8, 0);

    // Maximum job length
    start_job(15);
    for (int i = 0; i < 15; i++) feed(1);
    expect_result("j9", 15, 0);

    // Random traffic; the per-cycle compare does the checking
    for (int c = 0; c < 4000; c++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      start     = ($urandom_range(0, 3) == 0);
      num_terms = ($urandom_range(0, 3) == 0) ? 4'd15 : CNT_W'($urandom_range(0, 15));
      op_valid  = ($urandom_range(0, 9) < 6);
      op_data   = WIDTH'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    rst_n = 1'b1; start = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
